// File: rtl/s32x_video_mixer.sv
// 32X / MD video mixer: delays the 32X pixel stream to line up with the MD pipeline, selects per dot, expands to RGB888.
// Latency: one dot from the MD inputs (outputs register on the DOT_CE edge); 32X pixels are additionally delayed by DELAY dots.
// Backpressure: none; the block is paced entirely by DOT_CE and must accept one pixel per strobe.
`timescale 1ns/1ps
module s32x_video_mixer #(
    parameter int DELAY = 4,
    parameter int DEPTH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       DOT_CE,
    input  logic       S32X_EN,
    input  logic [4:0] S32X_R,
    input  logic [4:0] S32X_G,
    input  logic [4:0] S32X_B,
    input  logic       S32X_YSO_N,
    input  logic [3:0] MD_R,
    input  logic [3:0] MD_G,
    input  logic [3:0] MD_B,
    input  logic       MD_HBLK,
    input  logic       MD_VBLK,
    input  logic       MD_HS_N,
    input  logic       MD_VS_N,
    output logic [7:0] R,
    output logic [7:0] G,
    output logic [7:0] B,
    output logic       HBLK,
    output logic       VBLK,
    output logic       HS_N,
    output logic       VS_N,
    output logic       PIX_SRC
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] DELAY_A = AW'(DELAY);
    localparam logic [AW:0]   DELAY_F = (AW+1)'(DELAY);
    localparam logic [AW-1:0] ONE_A   = AW'(1);
    localparam logic [AW:0]   ONE_F   = (AW+1)'(1);

    // Reject configurations where the pointer arithmetic would not wrap correctly
    // or where the read pointer would collide with the write pointer.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("s32x_video_mixer: DEPTH must be a power of two and at least 2");
    end
    if (DELAY < 0 || DELAY >= DEPTH) begin : g_bad_delay
        $error("s32x_video_mixer: DELAY must lie in 0..DEPTH-1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wp_q, wp_d;
    logic [AW-1:0]   fc_q, fc_d;
    logic [AW:0]     fc_inc;
    logic            wr_en;
    logic [15:0]     wr_dat;
    logic [AW-1:0]   rd_addr;
    logic [15:0]     rd_dat;
    logic [15:0]     mem_q [DEPTH];

    logic            blank;
    logic            sel;
    logic [7:0]      r_q, r_d;
    logic [7:0]      g_q, g_d;
    logic [7:0]      b_q, b_d;
    logic            hblk_q, hblk_d;
    logic            vblk_q, vblk_d;
    logic            hs_n_q, hs_n_d;
    logic            vs_n_q, vs_n_d;
    logic            src_q, src_d;

    // Entry layout {YSO_N, B5, G5, R5}; the read sits DELAY entries behind the write.
    assign wr_dat  = {S32X_YSO_N, S32X_B, S32X_G, S32X_R};
    assign rd_addr = wp_q - DELAY_A;
    assign rd_dat  = (DELAY == 0) ? wr_dat : mem_q[rd_addr];
    assign fc_inc  = {1'b0, fc_q} + ONE_F;

    // Sequencer: disable wins over everything; FILL primes DELAY entries before RUN reads them.
    always_comb begin
        state_d = state_q;
        wp_d    = wp_q;
        fc_d    = fc_q;
        wr_en   = 1'b0;
        if (!S32X_EN) begin
            state_d = ST_IDLE;
            wp_d    = '0;
            fc_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    fc_d    = '0;
                    state_d = (DELAY == 0) ? ST_RUN : ST_FILL;
                end
                ST_FILL: begin
                    if (DOT_CE) begin
                        wr_en = 1'b1;
                        wp_d  = wp_q + ONE_A;
                        fc_d  = fc_inc[AW-1:0];
                        if (fc_inc == DELAY_F) begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (DOT_CE) begin
                        wr_en = 1'b1;
                        wp_d  = wp_q + ONE_A;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    wp_d    = '0;
                    fc_d    = '0;
                end
            endcase
        end
    end

    // Sequencer state; buffer contents are deliberately not reset since FILL hides stale data.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            wp_q    <= '0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            fc_q    <= fc_d;
        end
    end

    // Circular delay line for the 32X pixel stream.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wp_q] <= wr_dat;
        end
    end

    // Per-dot pixel select and bit-replicating expansion; everything holds between strobes.
    always_comb begin
        blank  = MD_HBLK | MD_VBLK;
        sel    = (state_q == ST_RUN) & ~rd_dat[15] & ~blank;
        r_d    = r_q;
        g_d    = g_q;
        b_d    = b_q;
        hblk_d = hblk_q;
        vblk_d = vblk_q;
        hs_n_d = hs_n_q;
        vs_n_d = vs_n_q;
        src_d  = src_q;
        if (DOT_CE) begin
            hblk_d = MD_HBLK;
            vblk_d = MD_VBLK;
            hs_n_d = MD_HS_N;
            vs_n_d = MD_VS_N;
            src_d  = sel;
            if (blank) begin
                r_d = 8'h00;
                g_d = 8'h00;
                b_d = 8'h00;
            end else if (sel) begin
                r_d = {rd_dat[4:0],   rd_dat[4:2]};
                g_d = {rd_dat[9:5],   rd_dat[9:7]};
                b_d = {rd_dat[14:10], rd_dat[14:12]};
            end else begin
                r_d = {MD_R, MD_R};
                g_d = {MD_G, MD_G};
                b_d = {MD_B, MD_B};
            end
        end
    end

    // Output register: blanked colour, syncs inactive, blanks asserted out of reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_q    <= 8'h00;
            g_q    <= 8'h00;
            b_q    <= 8'h00;
            hblk_q <= 1'b1;
            vblk_q <= 1'b1;
            hs_n_q <= 1'b1;
            vs_n_q <= 1'b1;
            src_q  <= 1'b0;
        end else begin
            r_q    <= r_d;
            g_q    <= g_d;
            b_q    <= b_d;
            hblk_q <= hblk_d;
            vblk_q <= vblk_d;
            hs_n_q <= hs_n_d;
            vs_n_q <= vs_n_d;
            src_q  <= src_d;
        end
    end

    assign R       = r_q;
    assign G       = g_q;
    assign B       = b_q;
    assign HBLK    = hblk_q;
    assign VBLK    = vblk_q;
    assign HS_N    = hs_n_q;
    assign VS_N    = vs_n_q;
    assign PIX_SRC = src_q;

endmodule

// File: tb/tb_s32x_video_mixer.sv
// Bench for s32x_video_mixer: a DELAY=4 instance checked by a scoreboard every cycle plus
// a table and hand sequences; a DELAY=0 instance on the same inputs checked by hand.
// DOT_CE strobes every other clock; inputs are scrambled in the gap cycles to expose missing holds.
`timescale 1ns/1ps
module tb_s32x_video_mixer;

    localparam int DLY = 4;

    logic       CLK = 1'b0;
    logic       RST, DOT_CE, S32X_EN;
    logic [4:0] S32X_R, S32X_G, S32X_B;
    logic       S32X_YSO_N;
    logic [3:0] MD_R, MD_G, MD_B;
    logic       MD_HBLK, MD_VBLK, MD_HS_N, MD_VS_N;
    logic [7:0] R, G, B;
    logic       HBLK, VBLK, HS_N, VS_N, PIX_SRC;
    logic [7:0] r0, g0, b0;
    logic       hblk0, vblk0, hs_n0, vs_n0, src0;

    always #5 CLK = ~CLK;

    s32x_video_mixer #(.DELAY(DLY), .DEPTH(8)) dut (
        .CLK(CLK), .RST(RST), .DOT_CE(DOT_CE), .S32X_EN(S32X_EN),
        .S32X_R(S32X_R), .S32X_G(S32X_G), .S32X_B(S32X_B), .S32X_YSO_N(S32X_YSO_N),
        .MD_R(MD_R), .MD_G(MD_G), .MD_B(MD_B),
        .MD_HBLK(MD_HBLK), .MD_VBLK(MD_VBLK), .MD_HS_N(MD_HS_N), .MD_VS_N(MD_VS_N),
        .R(R), .G(G), .B(B), .HBLK(HBLK), .VBLK(VBLK), .HS_N(HS_N), .VS_N(VS_N),
        .PIX_SRC(PIX_SRC)
    );

    s32x_video_mixer #(.DELAY(0), .DEPTH(8)) dut0 (
        .CLK(CLK), .RST(RST), .DOT_CE(DOT_CE), .S32X_EN(S32X_EN),
        .S32X_R(S32X_R), .S32X_G(S32X_G), .S32X_B(S32X_B), .S32X_YSO_N(S32X_YSO_N),
        .MD_R(MD_R), .MD_G(MD_G), .MD_B(MD_B),
        .MD_HBLK(MD_HBLK), .MD_VBLK(MD_VBLK), .MD_HS_N(MD_HS_N), .MD_VS_N(MD_VS_N),
        .R(r0), .G(g0), .B(b0), .HBLK(hblk0), .VBLK(vblk0), .HS_N(hs_n0), .VS_N(vs_n0),
        .PIX_SRC(src0)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] x5(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

    function automatic logic [7:0] x4(input logic [3:0] c);
        return {c, c};
    endfunction

    // ---------------- scoreboard model (DELAY=4 instance) ----------------
    int          m_state = 0;   // 0 idle, 1 fill, 2 run
    int          m_fc    = 0;
    logic [15:0] hist[$];
    logic [28:0] sb[$];
    logic [28:0] last_exp = '0;
    bit          edge_out = 1'b0;
    bit          mon_on   = 1'b0;

    always @(posedge CLK) begin : model
        logic [15:0] cur, rd;
        logic        sel, blank;
        logic [7:0]  er, eg, eb;
        edge_out = 1'b0;
        cur = {S32X_YSO_N, S32X_B, S32X_G, S32X_R};
        if (RST) begin
            m_state = 0;
            m_fc    = 0;
            hist.delete();
            sb.push_back({24'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
            edge_out = 1'b1;
            mon_on   = 1'b1;
        end else begin
            if (DOT_CE) begin
                rd    = (m_state == 2) ? hist[hist.size() - DLY] : 16'hFFFF;
                blank = MD_HBLK | MD_VBLK;
                sel   = (m_state == 2) && !rd[15] && !blank;
                if (blank) begin
                    er = 8'h00; eg = 8'h00; eb = 8'h00;
                end else if (sel) begin
                    er = x5(rd[4:0]); eg = x5(rd[9:5]); eb = x5(rd[14:10]);
                end else begin
                    er = x4(MD_R); eg = x4(MD_G); eb = x4(MD_B);
                end
                sb.push_back({er, eg, eb, MD_HBLK, MD_VBLK, MD_HS_N, MD_VS_N, sel});
                edge_out = 1'b1;
            end
            if (!S32X_EN) begin
                m_state = 0;
                m_fc    = 0;
                hist.delete();
            end else if (m_state == 0) begin
                m_state = 1;
            end else if (DOT_CE) begin
                hist.push_back(cur);
                if (m_state == 1) begin
                    m_fc++;
                    if (m_fc == DLY) m_state = 2;
                end
                if (hist.size() > 2 * DLY) void'(hist.pop_front());
            end
        end
    end

    always @(negedge CLK) begin : monitor
        logic [28:0] act, e;
        if (mon_on) begin
            act = {R, G, B, HBLK, VBLK, HS_N, VS_N, PIX_SRC};
            if (edge_out) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    check("sb_out", 32'(act), 32'(e));
                    last_exp = e;
                end
            end else begin
                check("sb_hold", 32'(act), 32'(last_exp));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic dot(input logic [4:0] sr, input logic [4:0] sg, input logic [4:0] sbl,
                       input logic yso, input logic [3:0] mr, input logic [3:0] mg,
                       input logic [3:0] mb, input logic hb, input logic vb,
                       input logic hs, input logic vs);
        S32X_R = sr; S32X_G = sg; S32X_B = sbl; S32X_YSO_N = yso;
        MD_R = mr; MD_G = mg; MD_B = mb;
        MD_HBLK = hb; MD_VBLK = vb; MD_HS_N = hs; MD_VS_N = vs;
        DOT_CE = 1'b1;
        @(negedge CLK);
        DOT_CE = 1'b0;
    endtask

    task automatic gap();
        S32X_R = 5'($urandom); S32X_G = 5'($urandom); S32X_B = 5'($urandom);
        S32X_YSO_N = 1'($urandom);
        MD_R = 4'($urandom); MD_G = 4'($urandom); MD_B = 4'($urandom);
        MD_HBLK = 1'($urandom); MD_VBLK = 1'($urandom);
        MD_HS_N = 1'($urandom); MD_VS_N = 1'($urandom);
        @(negedge CLK);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rgb"},  32'({R, G, B}), 32'h0);
        check({tag, "_blk"},  32'({HBLK, VBLK, HS_N, VS_N, PIX_SRC}), 32'b11110);
        check({tag, "_rgb0"}, 32'({r0, g0, b0}), 32'h0);
        check({tag, "_blk0"}, 32'({hblk0, vblk0, hs_n0, vs_n0, src0}), 32'b11110);
    endtask

    typedef struct {
        logic [3:0] mr, mg, mb;
        logic       hb, vb, hs, vs;
        logic [4:0] sr;
        logic       yso;
        logic [7:0] er, eg, eb;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4'hA, 4'hA, 4'hA, 1'b0, 1'b0, 1'b1, 1'b1, 5'h1F, 1'b0, 8'hAA, 8'hAA, 8'hAA};
        tbl[1] = '{4'h0, 4'h5, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 5'h00, 1'b0, 8'h00, 8'h55, 8'hFF};
        tbl[2] = '{4'h1, 4'h2, 4'h3, 1'b1, 1'b0, 1'b1, 1'b0, 5'h10, 1'b1, 8'h00, 8'h00, 8'h00};
        tbl[3] = '{4'hF, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 5'h05, 1'b0, 8'h00, 8'h00, 8'h00};
        tbl[4] = '{4'h7, 4'h8, 4'h9, 1'b0, 1'b0, 1'b1, 1'b1, 5'h0C, 1'b1, 8'h77, 8'h88, 8'h99};

        RST = 1'b1; DOT_CE = 1'b0; S32X_EN = 1'b0;
        S32X_R = '0; S32X_G = '0; S32X_B = '0; S32X_YSO_N = 1'b1;
        MD_R = '0; MD_G = '0; MD_B = '0;
        MD_HBLK = 1'b0; MD_VBLK = 1'b0; MD_HS_N = 1'b1; MD_VS_N = 1'b1;
        @(negedge CLK);
        check_reset("por");
        RST = 1'b0;

        // Adapter disabled: MD passthrough even with an opaque 32X pixel on the bus.
        for (int i = 0; i < 10; i++) begin
            dot(5'h1F, 5'h1F, 5'h1F, 1'b0, 4'hA, 4'hA, 4'hA, 1'b0, 1'b0, 1'b1, 1'b1);
            check("pass_rgb", 32'({R, G, B}), 32'hAAAAAA);
            check("pass_src", 32'(PIX_SRC), 32'd0);
            gap();
        end

        for (int i = 0; i < 5; i++) begin
            dot(tbl[i].sr, tbl[i].sr, tbl[i].sr, tbl[i].yso, tbl[i].mr, tbl[i].mg, tbl[i].mb,
                tbl[i].hb, tbl[i].vb, tbl[i].hs, tbl[i].vs);
            check("tbl_rgb", 32'({R, G, B}), 32'({tbl[i].er, tbl[i].eg, tbl[i].eb}));
            check("tbl_ctl", 32'({HBLK, VBLK, HS_N, VS_N, PIX_SRC}),
                  32'({tbl[i].hb, tbl[i].vb, tbl[i].hs, tbl[i].vs, 1'b0}));
            gap();
        end

        // Enable and ramp: 4 MD dots during fill, then the ramp 4 dots late; DELAY=0 shows it at once.
        S32X_EN = 1'b1;
        gap();
        for (int i = 0; i < 40; i++) begin
            dot(5'(i), 5'h0A, 5'h15, 1'b0, 4'h3, 4'h3, 4'h3, 1'b0, 1'b0, 1'b1, 1'b1);
            if (i < DLY) begin
                check("fill_r", 32'(R), 32'h33);
                check("fill_src", 32'(PIX_SRC), 32'd0);
            end else begin
                check("ramp_src", 32'(PIX_SRC), 32'd1);
                check("ramp_r", 32'(R), 32'(x5(5'(i - DLY))));
                check("ramp_gb", 32'({G, B}), 32'h52AD);
                if (5'(i - DLY) == 5'h1F) check("ramp_1f", 32'(R), 32'hFF);
            end
            check("d0_r", 32'(r0), 32'(x5(5'(i))));
            check("d0_src", 32'(src0), 32'd1);
            gap();
        end

        // YSO_N toggling per dot: source select follows 4 dots later.
        for (int i = 0; i < 16; i++) begin
            dot(5'(i + 7), 5'h01, 5'h02, i[0], 4'h6, 4'h6, 4'h6, 1'b0, 1'b0, 1'b1, 1'b1);
            if (i >= DLY) begin
                check("tog_src", 32'(PIX_SRC), 32'(!i[0]));
                check("tog_r", 32'(R), i[0] ? 32'h66 : 32'(x5(5'(i - DLY + 7))));
            end
            check("tog_src0", 32'(src0), 32'(!i[0]));
            check("tog_r0", 32'(r0), i[0] ? 32'h66 : 32'(x5(5'(i + 7))));
            gap();
        end

        // Horizontal blank over opaque 32X pixels forces black and MD source.
        for (int i = 0; i < 8; i++) begin
            dot(5'h1F, 5'h1F, 5'h1F, 1'b0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 1'b1);
            check("hblk_rgb", 32'({R, G, B}), 32'h0);
            check("hblk_ctl", 32'({HBLK, PIX_SRC}), 32'b10);
            gap();
        end

        // Disable on a DOT_CE cycle, run disabled, then re-enable: fill phase repeats.
        S32X_EN = 1'b0;
        dot(5'h11, 5'h11, 5'h11, 1'b0, 4'h2, 4'h2, 4'h2, 1'b0, 1'b0, 1'b1, 1'b1);
        gap();
        for (int i = 0; i < 3; i++) begin
            dot(5'h1E, 5'h1E, 5'h1E, 1'b0, 4'hC, 4'h4, 4'h8, 1'b0, 1'b0, 1'b1, 1'b1);
            check("off_rgb", 32'({R, G, B}), 32'hCC4488);
            check("off_src", 32'({PIX_SRC, src0}), 32'b00);
            gap();
        end
        S32X_EN = 1'b1;
        gap();
        for (int i = 0; i < 8; i++) begin
            dot(5'(i + 3), 5'h00, 5'h00, 1'b0, 4'h9, 4'h9, 4'h9, 1'b0, 1'b0, 1'b1, 1'b1);
            check("refill_src", 32'(PIX_SRC), (i < DLY) ? 32'd0 : 32'd1);
            check("refill_r", 32'(R), (i < DLY) ? 32'h99 : 32'(x5(5'(i - DLY + 3))));
            gap();
        end

        // Reset in the middle of RUN, then recover through a fresh fill.
        RST = 1'b1;
        @(negedge CLK);
        check_reset("mid");
        RST = 1'b0;
        gap();
        for (int i = 0; i < 8; i++) begin
            dot(5'(i + 20), 5'h03, 5'h03, 1'b0, 4'h5, 4'h5, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1);
            check("rst_src", 32'(PIX_SRC), (i < DLY) ? 32'd0 : 32'd1);
            check("rst_r", 32'(R), (i < DLY) ? 32'h55 : 32'(x5(5'(i - DLY + 20))));
            check("rst_r0", 32'({src0, r0}), 32'({1'b1, x5(5'(i + 20))}));
            gap();
        end

        repeat (2) @(negedge CLK);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover count=%0d", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/s32x_video_mixer.md
Name: s32x_video_mixer

Overview:
- Sits directly downstream of the 32X VDP. Consumes its 5:5:5 RGB and YSO_N pixel-source flag, plus the MD VDP's 4:4:4 RGB, blanks and syncs.
- Delays the 32X pixel stream by a programmable number of dots so it lines up with the MD pipeline.
- Selects the 32X or MD pixel per dot, expands both to 8 bits per channel, and emits registered video with aligned syncs and blanks to the scaler/output stage.

Parameters:
- DELAY, 4, dots of delay applied to the 32X stream; 0 = bypass. Legal range 0..DEPTH-1.
- DEPTH, 8, circular buffer depth in entries; power of two.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-high
- DOT_CE  in  1  one-cycle dot strobe; same strobe that clocks the 32X VDP pixel output
- S32X_EN  in  1  32X adapter enabled (ADEN); low = MD passthrough
- S32X_R / S32X_G / S32X_B  in  5 each  32X VDP colour
- S32X_YSO_N  in  1  0 = 32X pixel wins, 1 = MD pixel wins
- MD_R / MD_G / MD_B  in  4 each  MD VDP colour
- MD_HBLK / MD_VBLK  in  1 each  MD blanking, active-high
- MD_HS_N / MD_VS_N  in  1 each  MD syncs, active-low
- R / G / B  out  8 each  mixed colour
- HBLK / VBLK  out  1 each  delayed blanks
- HS_N / VS_N  out  1 each  delayed syncs
- PIX_SRC  out  1  1 = current output pixel came from 32X

Behaviour:
- Reset: R=G=B=0, HBLK=VBLK=1, HS_N=VS_N=1, PIX_SRC=0. Write pointer WP=0, fill counter FC=0, state=IDLE.
- Buffer:
  - Entry is 16 bits {YSO_N, B5, G5, R5}.
  - On each DOT_CE in FILL or RUN: write the entry at WP, then WP <= WP+1 (mod DEPTH).
  - Read address RP = (WP - DELAY) mod DEPTH.
  - If DELAY=0, the read data is the live input, not buffer contents.
- States:
  - IDLE: no writes; FC=0. When S32X_EN=1, go to FILL on the next CLK.
  - FILL: on each DOT_CE, FC <= FC+1. When FC reaches DELAY on a DOT_CE, go to RUN on that same edge. If DELAY=0, go IDLE→RUN directly.
  - RUN: steady state.
  - From any state, S32X_EN=0 forces IDLE on the next CLK and clears WP and FC.
- Simultaneity: if S32X_EN falls on a DOT_CE cycle, the write is suppressed and the state goes to IDLE.
- Output stage:
  - Updates only on DOT_CE and is registered, so outputs change one CLK after the DOT_CE edge; total latency is 1 dot from the MD inputs.
  - HBLK, VBLK, HS_N, VS_N are the MD inputs registered on DOT_CE.
  - sel = (state==RUN) & ~rdYSO_N & ~MD_HBLK & ~MD_VBLK.
  - PIX_SRC <= sel.
  - 32X expansion: ch8 = {c5, c5[4:2]}.
  - MD expansion: ch8 = {c4, c4}.
  - If MD_HBLK|MD_VBLK, then R=G=B=0 regardless of sel.
- Syncs and blanks are never delayed by DELAY; only the 32X pixel data is.
- Between DOT_CE strobes all outputs hold.
- Reset mid-operation: behaves exactly as power-on reset. Buffer contents need not be cleared, because FILL guarantees stale entries are never read.
- Wrap-around: pointers wrap silently at DEPTH. No overflow is possible because one write and one read occur per dot.
- Elaboration: DELAY >= DEPTH or a non-power-of-two DEPTH causes an elaboration error.

Test Plan:
1. Reset, S32X_EN=0, MD_R/G/B=4'hA, blanks=0, 10 DOT_CE -> R=G=B=8'hAA, PIX_SRC=0 throughout.
2. DELAY=4, S32X_EN rises, YSO_N=0, S32X_R ramps 0,1,2... on each DOT_CE:
   - For the first 4 dots after the enable, output is MD with PIX_SRC=0.
   - After that, R tracks the ramp 4 dots late, and S32X_R=5'h1F gives R=8'hFF.
3. In RUN, YSO_N toggles per dot -> PIX_SRC toggles 4 dots later. Output alternates {c5,c5[4:2]} and {c4,c4}.
4. In RUN, MD_HBLK=1 for 8 dots while the 32X pixel is opaque -> R=G=B=0, PIX_SRC=0, HBLK=1 one CLK after each DOT_CE.
5. S32X_EN drops mid-line on a DOT_CE cycle, then re-rises:
   - IDLE next CLK; WP=0.
   - On re-enable, the FILL phase repeats: MD is output for 4 dots before 32X pixels reappear.
6. DELAY=0 -> the 32X pixel appears at the output one CLK after the same DOT_CE with no fill gap. RST asserted mid-RUN -> all outputs at reset values next CLK.
